aexm_dcache_resp: RTL and testbench

- Responder end of the CPU data-cache precycle interface; sits between the core's dcache port and a simple word-wide external memory port.
- Direct-mapped, write-through, no-write-allocate cache of one 32-bit word per line; the tag/data/valid arrays are internal.
- Drives the busy signal that stalls the core's enable logic during misses and memory writes.

---
 rtl/aexm_dcache_resp.sv | 168 ++++++++++++++++
 tb/tb_aexm_dcache_resp.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aexm_dcache_resp.sv
// Data-cache responder: direct-mapped, write-through, no-write-allocate, one word per line.
// Define AEXM_DCACHE_STATS_EN to add the stat_hits/stat_misses read-hit/read-miss counters.
module aexm_dcache_resp #(
   parameter int LINES_LOG2 = 6
) (
   input  logic        sys_clk_i,
   input  logic        sys_rst_i,
   input  logic [31:0] cpu_precycle_addr,
   input  logic        cpu_precycle_enable,
   input  logic        cpu_precycle_we,
   input  logic [31:0] cpu_datao,
   output logic [31:0] cpu_datai,
   output logic        cpu_cache_busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
`ifdef AEXM_DCACHE_STATS_EN
   ,
   output logic [31:0] stat_hits,
   output logic [31:0] stat_misses
`endif
);

   localparam int LINES = 1 << LINES_LOG2;
   localparam int TAG_W = 30 - LINES_LOG2;

   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, DONE} stateT;

   stateT state, stateNext;

   logic [31:2]            reqAddr;
   logic                   reqWe;
   logic [31:0]            reqData;
   logic [31:0]            cpuDataReg;
   logic [LINES-1:0]       validBits;
   logic                   rdValid;
   logic [TAG_W-1:0]       rdTag;
   logic [31:0]            rdWord;
   logic [TAG_W-1:0]       tagMem  [LINES];
   logic [31:0]            dataMem [LINES];

   logic [LINES_LOG2-1:0]  newIdx, reqIdx;
   logic [TAG_W-1:0]       reqTag;
   logic                   hit;
   logic                   accept, readHit, readMiss, writeHit, fillWr;
   logic                   unusedAddrBits;

   assign newIdx         = cpu_precycle_addr[LINES_LOG2+1:2];
   assign reqIdx         = reqAddr[LINES_LOG2+1:2];
   assign reqTag         = reqAddr[31:LINES_LOG2+2];
   assign hit            = rdValid && (rdTag == reqTag);
   assign unusedAddrBits = ^cpu_precycle_addr[1:0];

   assign mem_addr  = {reqAddr, 2'b00};
   assign mem_wdata = reqData;

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) state <= IDLE;
      else           state <= stateNext;
   end

   always_comb begin
      stateNext      = state;
      cpu_cache_busy = 1'b0;
      cpu_datai      = cpuDataReg;
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      accept         = 1'b0;
      readHit        = 1'b0;
      readMiss       = 1'b0;
      writeHit       = 1'b0;
      fillWr         = 1'b0;
      case (state)
         IDLE: begin
            accept = cpu_precycle_enable;
            if (cpu_precycle_enable) stateNext = LOOKUP;
         end
         LOOKUP: begin
            if (reqWe) begin
               cpu_cache_busy = 1'b1;
               writeHit       = hit;
               stateNext      = WRITE;
            end else if (hit) begin
               // Hit data goes straight to the core; a new request may be taken now.
               readHit   = 1'b1;
               cpu_datai = rdWord;
               accept    = cpu_precycle_enable;
               stateNext = cpu_precycle_enable ? LOOKUP : IDLE;
            end else begin
               cpu_cache_busy = 1'b1;
               readMiss       = 1'b1;
               stateNext      = FILL;
            end
         end
         FILL: begin
            cpu_cache_busy = 1'b1;
            mem_req        = 1'b1;
            if (mem_ack) begin
               fillWr    = 1'b1;
               stateNext = DONE;
            end
         end
         WRITE: begin
            cpu_cache_busy = 1'b1;
            mem_req        = 1'b1;
            mem_we         = 1'b1;
            if (mem_ack) stateNext = DONE;
         end
         DONE: begin
            accept    = cpu_precycle_enable;
            stateNext = cpu_precycle_enable ? LOOKUP : IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         reqAddr    <= '0;
         reqWe      <= 1'b0;
         reqData    <= '0;
         cpuDataReg <= '0;
         validBits  <= '0;
         rdValid    <= 1'b0;
      end else begin
         if (accept) begin
            reqAddr <= cpu_precycle_addr[31:2];
            reqWe   <= cpu_precycle_we;
            reqData <= cpu_datao;
            rdValid <= validBits[newIdx];
         end
         if (fillWr) begin
            validBits[reqIdx] <= 1'b1;
            cpuDataReg        <= mem_rdata;
         end
         if (readHit) cpuDataReg <= rdWord;
      end
   end

   // Tag/data arrays and their synchronous read port carry no reset.
   always_ff @(posedge sys_clk_i) begin
      if (accept) begin
         rdTag  <= tagMem[newIdx];
         rdWord <= dataMem[newIdx];
      end
      if (fillWr) begin
         dataMem[reqIdx] <= mem_rdata;
         tagMem[reqIdx]  <= reqTag;
      end
      if (writeHit) dataMem[reqIdx] <= reqData;
   end

`ifdef AEXM_DCACHE_STATS_EN
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else begin
         if (readHit)  stat_hits   <= stat_hits + 32'd1;
         if (readMiss) stat_misses <= stat_misses + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_aexm_dcache_resp.sv
// Directed self-checking bench for aexm_dcache_resp (stats checks when AEXM_DCACHE_STATS_EN is defined).
module tb_aexm_dcache_resp;

   logic        sys_clk_i = 1'b0;
   logic        sys_rst_i = 1'b1;
   logic [31:0] cpu_precycle_addr = '0;
   logic        cpu_precycle_enable = 1'b0;
   logic        cpu_precycle_we = 1'b0;
   logic [31:0] cpu_datao = '0;
   logic [31:0] cpu_datai;
   logic        cpu_cache_busy;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
`ifdef AEXM_DCACHE_STATS_EN
   logic [31:0] stat_hits;
   logic [31:0] stat_misses;
`endif

   int nTests = 0;
   int nFail  = 0;

   aexm_dcache_resp #(.LINES_LOG2(6)) dut (
      .sys_clk_i(sys_clk_i),
      .sys_rst_i(sys_rst_i),
      .cpu_precycle_addr(cpu_precycle_addr),
      .cpu_precycle_enable(cpu_precycle_enable),
      .cpu_precycle_we(cpu_precycle_we),
      .cpu_datao(cpu_datao),
      .cpu_datai(cpu_datai),
      .cpu_cache_busy(cpu_cache_busy),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ack(mem_ack)
`ifdef AEXM_DCACHE_STATS_EN
      ,
      .stat_hits(stat_hits),
      .stat_misses(stat_misses)
`endif
   );

   always #5 sys_clk_i = ~sys_clk_i;

   // Present one request at the current falling edge; returns at the LOOKUP-cycle falling edge.
   task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
      cpu_precycle_addr   = a;
      cpu_precycle_we     = w;
      cpu_datao           = d;
      cpu_precycle_enable = 1'b1;
      @(negedge sys_clk_i);
      cpu_precycle_enable = 1'b0;
   endtask

   // Memory answers in the n-th FILL/WRITE cycle; returns at the DONE-cycle falling edge.
   task automatic serveMem(input int n, input logic [31:0] d);
      repeat (n) @(negedge sys_clk_i);
      mem_rdata = d;
      mem_ack   = 1'b1;
      @(negedge sys_clk_i);
      mem_ack   = 1'b0;
   endtask

   task automatic test_reset;
      nTests++; if (cpu_cache_busy !== 1'b0) begin nFail++; $display("FAIL rst_busy: got %b want 0", cpu_cache_busy); end
      nTests++; if (mem_req !== 1'b0) begin nFail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
      nTests++; if (mem_we !== 1'b0) begin nFail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
      nTests++; if (mem_addr !== 32'h0) begin nFail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
      nTests++; if (mem_wdata !== 32'h0) begin nFail++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
      nTests++; if (cpu_datai !== 32'h0) begin nFail++; $display("FAIL rst_datai: got %h want 0", cpu_datai); end
`ifdef AEXM_DCACHE_STATS_EN
      nTests++; if (stat_hits !== 32'h0 || stat_misses !== 32'h0) begin nFail++; $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_hits, stat_misses); end
`endif
   endtask

   task automatic test_read_miss;
      issue(32'h0000_0100, 1'b0, 32'h0);
      nTests++; if (cpu_cache_busy !== 1'b1) begin nFail++; $display("FAIL miss_lookup_busy: got %b want 1", cpu_cache_busy); end
      nTests++; if (mem_req !== 1'b0) begin nFail++; $display("FAIL miss_lookup_req: got %b want 0", mem_req); end
      @(negedge sys_clk_i);
      nTests++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin nFail++; $display("FAIL fill_req: got req=%b we=%b want 1/0", mem_req, mem_we); end
      nTests++; if (mem_addr !== 32'h0000_0100) begin nFail++; $display("FAIL fill_addr: got %h want 00000100", mem_addr); end
      nTests++; if (cpu_cache_busy !== 1'b1) begin nFail++; $display("FAIL fill_busy: got %b want 1", cpu_cache_busy); end
      // A request while busy must be ignored.
      cpu_precycle_addr   = 32'h0000_0300;
      cpu_precycle_we     = 1'b1;
      cpu_datao           = 32'h9999_9999;
      cpu_precycle_enable = 1'b1;
      @(negedge sys_clk_i);
      cpu_precycle_enable = 1'b0;
      nTests++; if (mem_addr !== 32'h0000_0100 || mem_we !== 1'b0) begin nFail++; $display("FAIL busy_ignore: got addr=%h we=%b want 00000100/0", mem_addr, mem_we); end
      @(negedge sys_clk_i);
      nTests++; if (mem_req !== 1'b1) begin nFail++; $display("FAIL fill_req_held: got %b want 1", mem_req); end
      mem_rdata = 32'hDEAD_BEEF;
      mem_ack   = 1'b1;
      @(negedge sys_clk_i);
      mem_ack = 1'b0;
      nTests++; if (cpu_cache_busy !== 1'b0 || mem_req !== 1'b0) begin nFail++; $display("FAIL done_ctrl: got busy=%b req=%b want 0/0", cpu_cache_busy, mem_req); end
      nTests++; if (cpu_datai !== 32'hDEAD_BEEF) begin nFail++; $display("FAIL done_data: got %h want deadbeef", cpu_datai); end
`ifdef AEXM_DCACHE_STATS_EN
      nTests++; if (stat_misses !== 32'd1) begin nFail++; $display("FAIL stat_miss1: got %0d want 1", stat_misses); end
`endif
      @(negedge sys_clk_i);
   endtask

   task automatic test_read_hit;
      issue(32'h0000_0100, 1'b0, 32'h0);
      nTests++; if (cpu_cache_busy !== 1'b0) begin nFail++; $display("FAIL hit_busy: got %b want 0", cpu_cache_busy); end
      nTests++; if (cpu_datai !== 32'hDEAD_BEEF) begin nFail++; $display("FAIL hit_data: got %h want deadbeef", cpu_datai); end
      nTests++; if (mem_req !== 1'b0) begin nFail++; $display("FAIL hit_req: got %b want 0", mem_req); end
      @(negedge sys_clk_i);
      nTests++; if (cpu_cache_busy !== 1'b0 || mem_req !== 1'b0) begin nFail++; $display("FAIL hit_after: got busy=%b req=%b want 0/0", cpu_cache_busy, mem_req); end
`ifdef AEXM_DCACHE_STATS_EN
      nTests++; if (stat_hits !== 32'd1) begin nFail++; $display("FAIL stat_hit1: got %0d want 1", stat_hits); end
`endif
   endtask

   task automatic test_write_through;
      issue(32'h0000_0100, 1'b1, 32'h1234_5678);
      nTests++; if (cpu_cache_busy !== 1'b1) begin nFail++; $display("FAIL wr_lookup_busy: got %b want 1", cpu_cache_busy); end
      @(negedge sys_clk_i);
      nTests++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin nFail++; $display("FAIL wr_req: got req=%b we=%b want 1/1", mem_req, mem_we); end
      nTests++; if (mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h0000_0100) begin nFail++; $display("FAIL wr_bus: got %h@%h want 12345678@00000100", mem_wdata, mem_addr); end
      @(negedge sys_clk_i);
      nTests++; if (mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678) begin nFail++; $display("FAIL wr_held: got we=%b data=%h want 1/12345678", mem_we, mem_wdata); end
      mem_ack = 1'b1;
      @(negedge sys_clk_i);
      mem_ack = 1'b0;
      nTests++; if (cpu_cache_busy !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin nFail++; $display("FAIL wr_done: got busy=%b req=%b we=%b want 0/0/0", cpu_cache_busy, mem_req, mem_we); end
      nTests++; if (cpu_datai !== 32'hDEAD_BEEF) begin nFail++; $display("FAIL wr_datai_kept: got %h want deadbeef", cpu_datai); end
      issue(32'h0000_0100, 1'b0, 32'h0);
      nTests++; if (cpu_cache_busy !== 1'b0 || cpu_datai !== 32'h1234_5678) begin nFail++; $display("FAIL wr_readback: got busy=%b data=%h want 0/12345678", cpu_cache_busy, cpu_datai); end
`ifdef AEXM_DCACHE_STATS_EN
      nTests++; if (stat_hits !== 32'd2 || stat_misses !== 32'd1) begin nFail++; $display("FAIL stat_wr: got %0d/%0d want 2/1", stat_hits, stat_misses); end
`endif
      @(negedge sys_clk_i);
   endtask

   task automatic test_index_alias;
      issue(32'h0000_0100, 1'b0, 32'h0);
      nTests++; if (cpu_cache_busy !== 1'b0 || cpu_datai !== 32'h1234_5678) begin nFail++; $display("FAIL alias_first: got busy=%b data=%h want 0/12345678", cpu_cache_busy, cpu_datai); end
      issue(32'h0000_4100, 1'b0, 32'h0);
      nTests++; if (cpu_cache_busy !== 1'b1 || mem_addr !== 32'h0000_4100) begin nFail++; $display("FAIL alias_second_miss: got busy=%b addr=%h want 1/00004100", cpu_cache_busy, mem_addr); end
      serveMem(1, 32'hCAFE_F00D);
      nTests++; if (cpu_datai !== 32'hCAFE_F00D || cpu_cache_busy !== 1'b0) begin nFail++; $display("FAIL alias_second_fill: got data=%h busy=%b want cafef00d/0", cpu_datai, cpu_cache_busy); end
      issue(32'h0000_0100, 1'b0, 32'h0);
      nTests++; if (cpu_cache_busy !== 1'b1) begin nFail++; $display("FAIL alias_third_miss: got %b want 1", cpu_cache_busy); end
      serveMem(1, 32'h1234_5678);
      nTests++; if (cpu_datai !== 32'h1234_5678) begin nFail++; $display("FAIL alias_third_fill: got %h want 12345678", cpu_datai); end
`ifdef AEXM_DCACHE_STATS_EN
      nTests++; if (stat_hits !== 32'd3 || stat_misses !== 32'd3) begin nFail++; $display("FAIL stat_alias: got %0d/%0d want 3/3", stat_hits, stat_misses); end
`endif
      @(negedge sys_clk_i);
   endtask

   task automatic test_reset_mid_fill;
      issue(32'h0000_0200, 1'b0, 32'h0);
      nTests++; if (cpu_cache_busy !== 1'b1) begin nFail++; $display("FAIL rmf_lookup_busy: got %b want 1", cpu_cache_busy); end
      @(negedge sys_clk_i);
      nTests++; if (mem_req !== 1'b1) begin nFail++; $display("FAIL rmf_fill_req: got %b want 1", mem_req); end
      #2 sys_rst_i = 1'b1;
      #1;
      nTests++; if (mem_req !== 1'b0 || cpu_cache_busy !== 1'b0) begin nFail++; $display("FAIL rmf_async_drop: got req=%b busy=%b want 0/0", mem_req, cpu_cache_busy); end
      @(negedge sys_clk_i);
      sys_rst_i = 1'b0;
      mem_rdata = 32'h55AA_55AA;
      mem_ack   = 1'b1;
      @(negedge sys_clk_i);
      mem_ack = 1'b0;
      nTests++; if (mem_req !== 1'b0 || cpu_cache_busy !== 1'b0 || cpu_datai !== 32'h0) begin nFail++; $display("FAIL rmf_late_ack: got req=%b busy=%b data=%h want 0/0/00000000", mem_req, cpu_cache_busy, cpu_datai); end
`ifdef AEXM_DCACHE_STATS_EN
      nTests++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin nFail++; $display("FAIL rmf_stats_rst: got %0d/%0d want 0/0", stat_hits, stat_misses); end
`endif
      issue(32'h0000_0200, 1'b0, 32'h0);
      nTests++; if (cpu_cache_busy !== 1'b1) begin nFail++; $display("FAIL rmf_reread_miss: got %b want 1", cpu_cache_busy); end
      serveMem(1, 32'h1111_2222);
      nTests++; if (cpu_datai !== 32'h1111_2222) begin nFail++; $display("FAIL rmf_refill: got %h want 11112222", cpu_datai); end
      @(negedge sys_clk_i);
   endtask

   task automatic test_write_miss;
      issue(32'h0000_0180, 1'b1, 32'h7777_7777);
      nTests++; if (cpu_cache_busy !== 1'b1) begin nFail++; $display("FAIL wm_lookup_busy: got %b want 1", cpu_cache_busy); end
      @(negedge sys_clk_i);
      nTests++; if (mem_we !== 1'b1 || mem_addr !== 32'h0000_0180 || mem_wdata !== 32'h7777_7777) begin nFail++; $display("FAIL wm_bus: got we=%b %h@%h want 1 77777777@00000180", mem_we, mem_wdata, mem_addr); end
      mem_ack = 1'b1;
      @(negedge sys_clk_i);
      mem_ack = 1'b0;
      nTests++; if (cpu_datai !== 32'h1111_2222) begin nFail++; $display("FAIL wm_datai_kept: got %h want 11112222", cpu_datai); end
      issue(32'h0000_0180, 1'b0, 32'h0);
      nTests++; if (cpu_cache_busy !== 1'b1) begin nFail++; $display("FAIL wm_no_alloc: got busy=%b want 1", cpu_cache_busy); end
      serveMem(1, 32'h7777_7777);
      nTests++; if (cpu_datai !== 32'h7777_7777) begin nFail++; $display("FAIL wm_fill: got %h want 77777777", cpu_datai); end
      @(negedge sys_clk_i);
   endtask

   task automatic test_back_to_back;
      issue(32'h0000_0100, 1'b0, 32'h0);
      serveMem(1, 32'h1234_5678);
      issue(32'h0000_0104, 1'b0, 32'h0);
      serveMem(1, 32'hA5A5_A5A5);
      nTests++; if (cpu_datai !== 32'hA5A5_A5A5) begin nFail++; $display("FAIL b2b_prefill: got %h want a5a5a5a5", cpu_datai); end
`ifdef AEXM_DCACHE_STATS_EN
      nTests++; if (stat_hits !== 32'd0 || stat_misses !== 32'd4) begin nFail++; $display("FAIL b2b_stats_before: got %0d/%0d want 0/4", stat_hits, stat_misses); end
`endif
      cpu_precycle_addr   = 32'h0000_0100;
      cpu_precycle_we     = 1'b0;
      cpu_precycle_enable = 1'b1;
      @(negedge sys_clk_i);
      nTests++; if (cpu_cache_busy !== 1'b0 || cpu_datai !== 32'h1234_5678) begin nFail++; $display("FAIL b2b_first: got busy=%b data=%h want 0/12345678", cpu_cache_busy, cpu_datai); end
      cpu_precycle_addr = 32'h0000_0104;
      @(negedge sys_clk_i);
      cpu_precycle_enable = 1'b0;
      nTests++; if (cpu_cache_busy !== 1'b0 || cpu_datai !== 32'hA5A5_A5A5) begin nFail++; $display("FAIL b2b_second: got busy=%b data=%h want 0/a5a5a5a5", cpu_cache_busy, cpu_datai); end
      @(negedge sys_clk_i);
      nTests++; if (cpu_cache_busy !== 1'b0 || mem_req !== 1'b0 || cpu_datai !== 32'hA5A5_A5A5) begin nFail++; $display("FAIL b2b_idle: got busy=%b req=%b data=%h want 0/0/a5a5a5a5", cpu_cache_busy, mem_req, cpu_datai); end
`ifdef AEXM_DCACHE_STATS_EN
      nTests++; if (stat_hits !== 32'd2 || stat_misses !== 32'd4) begin nFail++; $display("FAIL b2b_stats_after: got %0d/%0d want 2/4", stat_hits, stat_misses); end
`endif
   endtask

   initial begin
      repeat (2) @(negedge sys_clk_i);
      test_reset();
      sys_rst_i = 1'b0;
      @(negedge sys_clk_i);
      test_read_miss();
      test_read_hit();
      test_write_through();
      test_index_alias();
      test_reset_mid_fill();
      test_write_miss();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
